life_engine: RTL and testbench
==============================

# life_engine

Parametrised Game-of-Life generation engine for the LED-matrix pipeline. It holds a ROWS×COLS grid for NCH independent colour channels and computes the next generation sequentially, one cell per cycle, into a shadow buffer. It commits all channels atomically and raises a one-cycle `done`. The frame controller seeds the grid, requests steps between frames, and streams pixels out through a registered read port into the WS2812B shift register.

## Interface
- `ROWS`, default 8: grid rows, ≥3.
- `COLS`, default 8: grid columns, ≥3.
- `NCH`, default 3: independent channels, bit order {G,R,B} at default.
- `WRAP`, default 1: 1 = toroidal neighbours; 0 = off-grid neighbours dead.
- Derived: `N = ROWS*COLS`; `AW = $clog2(N)`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `step` in 1: generation request, sampled in IDLE only.
- `busy` out 1: high from step acceptance through COMMIT.
- `done` out 1: one-cycle pulse on commit.
- `gen_count` out 16: committed generations, wraps 0xFFFF→0.
- `seed_we` in 1: write one cell of current state.
- `seed_addr` in AW: cell index = row*COLS+col.
- `seed_val` in NCH: per-channel alive bits.
- `rd_addr` in AW: read index.
- `rd_data` out NCH: current-state bits, registered.

## Operation
- State: `cur[NCH][N]` (displayed generation) and `nxt[NCH][N]` (shadow).
- FSM states: IDLE, SCAN, COMMIT.
- IDLE→SCAN on `step`. The scan index `idx` loads 0.
- SCAN: for each channel, count the 8 neighbours of cell `idx` in `cur`, apply B3/S23, write `nxt[ch][idx]`, then `idx++`.
- SCAN→COMMIT after `idx=N-1` is written.
- COMMIT: `cur<=nxt` for all channels at once, `gen_count++`, `done=1`, then IDLE.
- Neighbour count is 4-bit (0–8); no saturation needed.
- WRAP=1: row/col arithmetic is modulo ROWS/COLS. WRAP=0: out-of-range neighbours count as 0.
- Seed writes are honoured in IDLE only and ignored in SCAN/COMMIT. `seed_we` and `step` in the same IDLE cycle: the write lands in `cur` first, and the scan sees it.
- `step` in SCAN/COMMIT is ignored, not queued.
- `seed_addr ≥ N`: write ignored. `rd_addr ≥ N`: `rd_data=0`.
- `rd_data` always reflects `cur` (old generation during SCAN), so streaming never tears.
- Reset values: `cur`, `nxt`, `idx`, `gen_count`, `rd_data` = 0; `busy=0`; `done=0`; FSM=IDLE. Reset mid-SCAN discards the partial generation.

## Timing
- `step` high at edge E0 (IDLE): `busy=1` after E0.
- Cells 0..N-1 are written at E1..EN.
- COMMIT at EN+1: `cur`, `gen_count` and `done=1` are visible after EN+1, and `busy=0` after EN+1.
- `done` falls after EN+2.
- Step-to-done is N+1 cycles (65 at defaults).
- A new `step` can be accepted at EN+2.
- `rd_data` latency is 1 cycle from `rd_addr`. A read at the commit edge returns the old value; from the next edge it returns the new value.
- A seed write at edge E is readable through `rd_addr` at E+1, with `rd_data` valid after E+1.

## Structure
- Package `life_pkg`: FSM state enum `life_state_t`, the `GEN_W=16` constant, and the function `wrap_idx(r,c,ROWS,COLS,WRAP)` returning index plus valid.
- Sub-module `life_rule`: combinational. Takes 8 neighbour bits and the self bit, returns the next bit (B3/S23). Instantiate NCH times.
- Neighbour gather is indexed muxing from `cur` by `idx`.

## Test plan
- Blinker, ch0: seed (3,2),(3,3),(3,4) and pulse `step` → `done` 65 cycles later; ch0 alive exactly at (2,3),(3,3),(4,3); `gen_count=1`. A second step restores the horizontal pattern.
- Torus glider, WRAP=1: seed a glider at top-left, run 32 steps → grid identical to the seed, `gen_count=32`.
- Edge rule: 2×2 block at (0,0) is stable under both WRAP values. A blinker at row 0 cols 7,0,1 oscillates with WRAP=1 and dies within 2 steps with WRAP=0.
- Channel independence: blinker on ch0, block on ch1, ch2 empty, one step → each channel evolves alone; ch2 stays 0.
- Busy rules: `step` and `seed_we` at cycle 10 of SCAN → no effect; `gen_count` increments once. Reads during SCAN return the pre-step grid.
- Reset mid-SCAN (cycle 30) → all outputs 0, FSM IDLE, `rd_data=0` everywhere. A subsequent step on the empty grid yields an empty grid and `gen_count=1`.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life generation engine.
package life_pkg;

  localparam int GEN_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } life_state_t;

  // Flat cell index plus a flag saying whether the neighbour exists at all.
  typedef struct packed {
    logic        vld;
    logic [30:0] idx;
  } cell_ref_t;

  // Map a possibly off-grid (r,c) to a flat index. With wrap the grid is a
  // torus; without it, anything off the edge is reported invalid (dead).
  function automatic cell_ref_t wrap_idx(input int r, input int c,
                                         input int rows, input int cols,
                                         input bit wrap);
    cell_ref_t res;
    int        rr;
    int        cc;
    rr      = r;
    cc      = c;
    res.vld = 1'b1;
    if (rr < 0) begin
      rr = rr + rows;
      if (!wrap) res.vld = 1'b0;
    end else if (rr >= rows) begin
      rr = rr - rows;
      if (!wrap) res.vld = 1'b0;
    end
    if (cc < 0) begin
      cc = cc + cols;
      if (!wrap) res.vld = 1'b0;
    end else if (cc >= cols) begin
      cc = cc - cols;
      if (!wrap) res.vld = 1'b0;
    end
    res.idx = res.vld ? 31'(rr * cols + cc) : '0;
    return res;
  endfunction

endpackage

// File: rtl/life_rule.sv
// B3/S23 rule for one cell of one channel.
module life_rule (
  input  logic [7:0] nb,
  input  logic       self_bit,
  output logic       next_bit
);

  logic [3:0] cnt;

  // Population of the 8 neighbours (0..8 fits in 4 bits).
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nb[i]};
  end

  // Birth on exactly 3, survival on 2 or 3.
  always_comb begin
    next_bit = (cnt == 4'd3) | (self_bit & (cnt == 4'd2));
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine: NCH independent grids, one cell per cycle
// into a shadow buffer, atomic commit with a one-cycle done pulse.
module life_engine
  import life_pkg::*;
#(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  parameter  int NCH  = 3,
  parameter  int WRAP = 1,
  localparam int N    = ROWS * COLS,
  localparam int AW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  input  logic             seed_we,
  input  logic [AW-1:0]    seed_addr,
  input  logic [NCH-1:0]   seed_val,
  input  logic [AW-1:0]    rd_addr,
  output logic [NCH-1:0]   rd_data
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW:0]   N_L   = (AW+1)'(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [CW-1:0] C_END = CW'(COLS - 1);

  life_state_t              state;
  logic [NCH-1:0][N-1:0]    cur;
  logic [NCH-1:0][N-1:0]    nxt;
  logic [AW-1:0]            idx;
  logic [RW-1:0]            row;
  logic [CW-1:0]            col;

  logic [NCH-1:0][7:0]      nb;
  logic [NCH-1:0]           self_bits;
  logic [NCH-1:0]           new_bits;
  logic [NCH-1:0]           rd_bits;
  logic                     seed_ok;
  logic                     rd_ok;

  assign seed_ok = ({1'b0, seed_addr} < N_L);
  assign rd_ok   = ({1'b0, rd_addr} < N_L);

  // Gather the 8 neighbours of the scan cell from cur; row/col shadow idx
  // so no divider is needed.
  always_comb begin
    cell_ref_t nref;
    logic [2:0] k;
    nb        = '0;
    self_bits = '0;
    k         = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          nref = wrap_idx(int'(row) + dr, int'(col) + dc, ROWS, COLS, WRAP != 0);
          for (int ch = 0; ch < NCH; ch++)
            nb[ch][k] = nref.vld & cur[ch][nref.idx[AW-1:0]];
          k = k + 3'd1;
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) self_bits[ch] = cur[ch][idx];
  end

  life_rule u_rule [NCH-1:0] (
    .nb       (nb),
    .self_bit (self_bits),
    .next_bit (new_bits)
  );

  // Read port mux; out-of-range addresses read as dead.
  always_comb begin
    rd_bits = '0;
    for (int ch = 0; ch < NCH; ch++)
      rd_bits[ch] = rd_ok ? cur[ch][rd_addr] : 1'b0;
  end

  // Control FSM with grid state: seeding in IDLE, scan into nxt, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      nxt       <= '0;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      gen_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // The seed write and a same-cycle step coexist: scan starts next
          // cycle, so it already sees the freshly written cell.
          if (seed_we && seed_ok)
            for (int ch = 0; ch < NCH; ch++) cur[ch][seed_addr] <= seed_val[ch];
          if (step) begin
            state <= S_SCAN;
            busy  <= 1'b1;
            idx   <= '0;
            row   <= '0;
            col   <= '0;
          end
        end
        S_SCAN: begin
          for (int ch = 0; ch < NCH; ch++) nxt[ch][idx] <= new_bits[ch];
          if (idx == LAST) begin
            state <= S_COMMIT;
          end else begin
            idx <= idx + 1'b1;
            if (col == C_END) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          cur       <= nxt;
          gen_count <= gen_count + 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered read port; always shows the displayed generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_bits;
  end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench: a torus and a bounded engine share stimulus; a reference
// model of the grids predicts done/gen_count and every read-port value.
module tb_life_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int NCH  = 3;
  localparam int N    = ROWS * COLS;
  localparam int AW   = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                step = 1'b0;
  logic                seed_we = 1'b0;
  logic [AW-1:0]       seed_addr = '0;
  logic [NCH-1:0]      seed_val = '0;
  logic [AW-1:0]       rd_addr = '0;
  logic [1:0]          busy;
  logic [1:0]          done;
  logic [1:0][15:0]    gen_count;
  logic [1:0][NCH-1:0] rd_data;

  // Index 0: toroidal engine, index 1: bounded engine.
  life_engine #(.ROWS(ROWS), .COLS(COLS), .NCH(NCH), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .step(step), .busy(busy[0]), .done(done[0]),
    .gen_count(gen_count[0]), .seed_we(seed_we), .seed_addr(seed_addr),
    .seed_val(seed_val), .rd_addr(rd_addr), .rd_data(rd_data[0]));

  life_engine #(.ROWS(ROWS), .COLS(COLS), .NCH(NCH), .WRAP(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .step(step), .busy(busy[1]), .done(done[1]),
    .gen_count(gen_count[1]), .seed_we(seed_we), .seed_addr(seed_addr),
    .seed_val(seed_val), .rd_addr(rd_addr), .rd_data(rd_data[1]));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] gen; } dexp_t;
  typedef struct { int addr; logic [NCH-1:0] v0; logic [NCH-1:0] v1; } rexp_t;
  dexp_t dq[$];
  rexp_t rq[$];
  dexp_t de;
  rexp_t re;

  bit         ref_g [2][NCH][N];
  logic [15:0] exp_gen = '0;

  logic rd_chk = 1'b0;
  logic rd_chk_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) rd_chk_q <= rd_chk;

  always @(negedge clk) begin
    if (rd_chk_q) begin
      if (rq.size() == 0) begin
        check("rd_underflow", 32'd1, 32'd0);
      end else begin
        re = rq.pop_front();
        check($sformatf("rd_w[%0d]", re.addr), 32'(rd_data[0]), 32'(re.v0));
        check($sformatf("rd_n[%0d]", re.addr), 32'(rd_data[1]), 32'(re.v1));
      end
    end
    if (done !== 2'b00) begin
      if (dq.size() == 0) begin
        check("done_spurious", 32'(done), 32'd0);
      end else begin
        de = dq.pop_front();
        check("done_both", 32'(done), 32'd3);
        check("done_cycle", 32'(cyc), 32'(de.cyc));
        check("gen_w", 32'(gen_count[0]), 32'(de.gen));
        check("gen_n", 32'(gen_count[1]), 32'(de.gen));
        check("busy_at_done", 32'(busy), 32'd0);
      end
      done_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int alive(input int d, input int ch, input int r, input int c);
    if (d == 0) begin
      r = (r + ROWS) % ROWS;
      c = (c + COLS) % COLS;
    end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
      return 0;
    end
    return ref_g[d][ch][r*COLS + c] ? 1 : 0;
  endfunction

  task automatic model_step();
    bit nx [2][NCH][N];
    int cnt;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) cnt += alive(d, ch, r + dr, c + dc);
            nx[d][ch][r*COLS + c] = (cnt == 3) || (ref_g[d][ch][r*COLS + c] && cnt == 2);
          end
    ref_g = nx;
  endtask

  function automatic logic [NCH-1:0] ref_val(input int d, input int a);
    logic [NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = ref_g[d][ch][a];
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_step();
    dexp_t e;
    exp_gen = exp_gen + 16'd1;
    e.cyc = cyc + N + 2;
    e.gen = exp_gen;
    dq.push_back(e);
  endtask

  task automatic seed_cell(input int a, input logic [NCH-1:0] v, input bit with_step);
    seed_we   = 1'b1;
    seed_addr = AW'(a);
    seed_val  = v;
    step      = with_step;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++) ref_g[d][ch][a] = v[ch];
    if (with_step) push_step();
    tick();
    seed_we = 1'b0;
    step    = 1'b0;
  endtask

  // Grids are identical between clear and the first step, so merging uses index 0.
  task automatic add_bits(input int r, input int c, input logic [NCH-1:0] m);
    int a;
    a = r*COLS + c;
    seed_cell(a, ref_val(0, a) | m, 1'b0);
  endtask

  task automatic clear_grid();
    for (int a = 0; a < N; a++) seed_cell(a, '0, 1'b0);
  endtask

  task automatic do_step();
    step = 1'b1;
    push_step();
    tick();
    step = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int k = 0; k < N + 20; k++) begin
      tick();
      if (done_cnt > start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd1, 32'd0);
    model_step();
  endtask

  task automatic read_range(input int n);
    rexp_t e;
    for (int a = 0; a < n; a++) begin
      rd_addr = AW'(a);
      rd_chk  = 1'b1;
      e.addr = a;
      e.v0   = ref_val(0, a);
      e.v1   = ref_val(1, a);
      rq.push_back(e);
      tick();
    end
    rd_chk = 1'b0;
  endtask

  task automatic step_and_check();
    do_step();
    wait_done();
    read_range(N);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();
    read_range(N);

    // Blinker on ch0; last seed shares its cycle with step
    seed_cell(3*COLS + 2, 3'b001, 1'b0);
    seed_cell(3*COLS + 3, 3'b001, 1'b0);
    seed_cell(3*COLS + 4, 3'b001, 1'b1);
    wait_done();
    check("blinker_v_top", 32'(ref_g[0][0][2*COLS+3]), 32'd1);
    read_range(N);
    step_and_check();

    // Glider on the torus, 32 generations
    clear_grid();
    add_bits(0, 1, 3'b001);
    add_bits(1, 2, 3'b001);
    add_bits(2, 0, 3'b001);
    add_bits(2, 1, 3'b001);
    add_bits(2, 2, 3'b001);
    for (int g = 0; g < 32; g++) step_and_check();

    // Edge: block at the corner on ch1, wrapping blinker on row 0 on ch0
    clear_grid();
    add_bits(0, 0, 3'b010);
    add_bits(0, 1, 3'b010);
    add_bits(1, 0, 3'b010);
    add_bits(1, 1, 3'b010);
    add_bits(0, 7, 3'b001);
    add_bits(0, 0, 3'b001);
    add_bits(0, 1, 3'b001);
    step_and_check();
    step_and_check();

    // Channel independence: blinker ch0, block ch1, ch2 empty
    clear_grid();
    add_bits(3, 2, 3'b001);
    add_bits(3, 3, 3'b001);
    add_bits(3, 4, 3'b001);
    add_bits(5, 5, 3'b010);
    add_bits(5, 6, 3'b010);
    add_bits(6, 5, 3'b010);
    add_bits(6, 6, 3'b010);
    step_and_check();

    // Busy: step/seed mid-scan are dropped; reads show the pre-step grid
    do_step();
    for (int k = 0; k < 9; k++) tick();
    check("busy_scan", 32'(busy), 32'd3);
    step      = 1'b1;
    seed_we   = 1'b1;
    seed_addr = '0;
    seed_val  = 3'b111;
    tick();
    step    = 1'b0;
    seed_we = 1'b0;
    read_range(40);
    wait_done();
    read_range(N);

    // Random soups
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < 16; s++)
        seed_cell(int'($urandom_range(0, N-1)), NCH'($urandom_range(0, 7)), 1'b0);
      step_and_check();
      step_and_check();
    end

    // Reset in the middle of a scan discards everything
    do_step();
    for (int k = 0; k < 29; k++) tick();
    rst_n = 1'b0;
    #1;
    dq.delete();
    exp_gen = '0;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++)
        for (int a = 0; a < N; a++) ref_g[d][ch][a] = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_gen", 32'(gen_count), 32'd0);
    check("mid_rst_rd", 32'(rd_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read_range(N);
    step_and_check();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
